pipeline_control_unit: RTL and testbench

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

---
 rtl/lapido_pkg.sv | 46 ++++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/pipeline_control_unit.sv | 128 ++++++++++++
 tb/tb_pipeline_control_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lapido_pkg.sv
// Shared FSM encoding, widths, register-zero constant and stage-control payloads
// for the Lapido pipeline control unit.
package lapido_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned WAIT_CNT_W  = 8;
    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } pcu_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                            id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                            ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    localparam stage_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                            id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                            ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
    localparam stage_ctrl_t CTRL_HALT   = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                            id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                            ex_mem_en: 1'b0, mem_wb_flush: 1'b0};
    localparam stage_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                            id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                            ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
    localparam stage_ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                            id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    localparam stage_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                            id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                            ex_mem_en: 1'b1, mem_wb_flush: 1'b0};

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready data-memory wait cycles and flags the last
// cycle tolerated before the access is declared timed out.
module mem_wait_timer
    import lapido_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_i,
    output logic expire_o
);

    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;

    // Counter only runs while the caller keeps counting; any other cycle clears it.
    always_comb begin
        wait_cnt_d = '0;
        if (count_i) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expire_o = count_i && (wait_cnt_q == WAIT_CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline hazard/stall controller: memory freeze with timeout, load-use and HI/LO stalls,
// branch flush. Optional stall counter enabled by LAPIDO_STALL_COUNTER_EN.
module pipeline_control_unit
    import lapido_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ID_EX_is_load,
    input  logic [REG_ADDR_W-1:0]  ID_EX_rt,
    input  logic [REG_ADDR_W-1:0]  IF_ID_rs,
    input  logic [REG_ADDR_W-1:0]  IF_ID_rt,
    input  logic                   branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    input  logic                   mdu_start,
    input  logic                   mdu_done,
    input  logic                   IF_ID_reads_hilo,
    output logic                   pc_en,
    output logic                   IF_ID_en,
    output logic                   IF_ID_flush,
    output logic                   ID_EX_en,
    output logic                   ID_EX_flush,
    output logic                   EX_MEM_en,
    output logic                   MEM_WB_flush,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    pcu_state_e  state_q;
    logic        mdu_busy_q;
    logic        freeze;
    logic        load_use;
    logic        hilo_hazard;
    logic        front_stall;
    logic        wait_count;
    logic        wait_expire;
    stage_ctrl_t ctrl;

    assign freeze      = dmem_req && !dmem_ready && (state_q != ST_TIMEOUT);
    assign load_use    = ID_EX_is_load && (ID_EX_rt != REG_ZERO) &&
                         ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
    assign hilo_hazard = IF_ID_reads_hilo && (mdu_start || (mdu_busy_q && !mdu_done));
    assign front_stall = load_use || hilo_hazard;
    assign wait_count  = (state_q == ST_MEM_WAIT) && !dmem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .count_i (wait_count),
        .expire_o(wait_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (freeze) state_q <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready)       state_q <= ST_RUN;
                    else if (wait_expire) state_q <= ST_TIMEOUT;
                end
                ST_TIMEOUT: state_q <= ST_TIMEOUT;
                default:    state_q <= ST_RUN;
            endcase
        end
    end

    // A timed-out pipeline is dead, so the MDU tracker freezes with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_busy_q <= 1'b0;
        end else if (state_q != ST_TIMEOUT) begin
            if (mdu_start)     mdu_busy_q <= 1'b1;
            else if (mdu_done) mdu_busy_q <= 1'b0;
        end
    end

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (rst)                                    ctrl = CTRL_RESET;
        else if (state_q == ST_TIMEOUT)             ctrl = CTRL_HALT;
        else if (freeze)                            ctrl = CTRL_FREEZE;
        else if (state_q == ST_RUN && front_stall)  ctrl = CTRL_STALL;
        else if (state_q == ST_RUN && branch_taken) ctrl = CTRL_BRANCH;
    end

    assign pc_en        = ctrl.pc_en;
    assign IF_ID_en     = ctrl.if_id_en;
    assign IF_ID_flush  = ctrl.if_id_flush;
    assign ID_EX_en     = ctrl.id_ex_en;
    assign ID_EX_flush  = ctrl.id_ex_flush;
    assign EX_MEM_en    = ctrl.ex_mem_en;
    assign MEM_WB_flush = ctrl.mem_wb_flush;
    assign mem_timeout  = (state_q == ST_TIMEOUT);

`ifdef LAPIDO_STALL_COUNTER_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: spec-level model checked every cycle
// plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_pipeline_control_unit;

    localparam int unsigned MT = 4;
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_TO   = 2;

    // {pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush}
    localparam logic [6:0] V_RESET  = 7'b0010101;
    localparam logic [6:0] V_NORMAL = 7'b1101010;
    localparam logic [6:0] V_FREEZE = 7'b0000001;
    localparam logic [6:0] V_STALL  = 7'b0001110;
    localparam logic [6:0] V_BRANCH = 7'b1111010;
    localparam logic [6:0] V_HALT   = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_EX_is_load;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        mdu_start;
    logic        mdu_done;
    logic        IF_ID_reads_hilo;
    logic        pc_en;
    logic        IF_ID_en;
    logic        IF_ID_flush;
    logic        ID_EX_en;
    logic        ID_EX_flush;
    logic        EX_MEM_en;
    logic        MEM_WB_flush;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    int          m_mode  = M_RUN;
    int          m_wait  = 0;
    bit          m_busy  = 1'b0;
    logic [31:0] m_stall = 32'd0;

    pipeline_control_unit #(.MEM_TIMEOUT(MT)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_EX_is_load   (ID_EX_is_load),
        .ID_EX_rt        (ID_EX_rt),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .branch_taken    (branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .mdu_start       (mdu_start),
        .mdu_done        (mdu_done),
        .IF_ID_reads_hilo(IF_ID_reads_hilo),
        .pc_en           (pc_en),
        .IF_ID_en        (IF_ID_en),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_en        (ID_EX_en),
        .ID_EX_flush     (ID_EX_flush),
        .EX_MEM_en       (EX_MEM_en),
        .MEM_WB_flush    (MEM_WB_flush),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush};
    endfunction

    // Expected stage controls from the priority rules, given model state and current inputs.
    function automatic logic [6:0] exp_vec();
        bit frz, lu, hz;
        frz = dmem_req && !dmem_ready && (m_mode != M_TO);
        lu  = ID_EX_is_load && (ID_EX_rt != 5'd0) &&
              ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
        hz  = IF_ID_reads_hilo && (mdu_start || (m_busy && !mdu_done));
        if (rst)                            return V_RESET;
        if (m_mode == M_TO)                 return V_HALT;
        if (frz)                            return V_FREEZE;
        if (m_mode == M_RUN && (lu || hz))  return V_STALL;
        if (m_mode == M_RUN && branch_taken) return V_BRANCH;
        return V_NORMAL;
    endfunction

    always @(negedge clk) begin
        logic [6:0] ev;
        ev = exp_vec();
        chk("model_ctrl", 32'(dut_vec()), 32'(ev));
        chk("model_mem_timeout", 32'(mem_timeout), 32'(!rst && (m_mode == M_TO)));
        chk("model_stall_cycles", stall_cycles, rst ? 32'd0 : m_stall);
        if (rst) begin
            m_mode  = M_RUN;
            m_wait  = 0;
            m_busy  = 1'b0;
            m_stall = 32'd0;
        end else begin
`ifdef LAPIDO_STALL_COUNTER_EN
            if (!ev[6] && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
`endif
            if (m_mode != M_TO) begin
                if (mdu_start)     m_busy = 1'b1;
                else if (mdu_done) m_busy = 1'b0;
            end
            case (m_mode)
                M_RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        m_mode = M_WAIT;
                        m_wait = 0;
                    end
                end
                M_WAIT: begin
                    if (dmem_ready) begin
                        m_mode = M_RUN;
                        m_wait = 0;
                    end else if (m_wait == int'(MT) - 1) begin
                        m_mode = M_TO;
                        m_wait = 0;
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic clr();
        ID_EX_is_load    = 1'b0;
        ID_EX_rt         = 5'd0;
        IF_ID_rs         = 5'd0;
        IF_ID_rt         = 5'd0;
        branch_taken     = 1'b0;
        dmem_req         = 1'b0;
        dmem_ready       = 1'b0;
        mdu_start        = 1'b0;
        mdu_done         = 1'b0;
        IF_ID_reads_hilo = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [6:0] exp);
        chk(nm, 32'(dut_vec()), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_st;
`ifdef LAPIDO_STALL_COUNTER_EN
        exp_st = 32'd6;
`else
        exp_st = 32'd0;
`endif
        rst = 1'b1;
        clr();
        branch_taken = 1'b1;
        dmem_req     = 1'b1;
        mdu_start    = 1'b1;
        settle();
        lit("reset_ctrl", V_RESET);
        chk("reset_mem_timeout", 32'(mem_timeout), 32'd0);
        chk("reset_stall_cycles", stall_cycles, 32'd0);
        adv();
        settle();
        lit("reset_ctrl_2", V_RESET);
        adv();
        rst = 1'b0;
        clr();
        settle();
        lit("idle_normal", V_NORMAL);

        // Load-use on rs, then released next cycle
        adv(); ID_EX_is_load = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
        settle(); lit("load_use_rs", V_STALL);
        adv(); clr();
        settle(); lit("after_load_use", V_NORMAL);
        adv(); ID_EX_is_load = 1'b1; ID_EX_rt = 5'd7; IF_ID_rt = 5'd7; IF_ID_rs = 5'd3;
        settle(); lit("load_use_rt", V_STALL);
        adv(); clr(); ID_EX_is_load = 1'b1;
        settle(); lit("load_r0_no_stall", V_NORMAL);
        adv(); clr(); ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
        settle(); lit("no_load_no_stall", V_NORMAL);

        // Branch under load-use is ignored; branch alone flushes IF/ID
        adv(); clr(); ID_EX_is_load = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5; branch_taken = 1'b1;
        settle(); lit("branch_with_load_use", V_STALL);
        adv(); clr(); branch_taken = 1'b1;
        settle(); lit("branch_alone", V_BRANCH);

        // Three not-ready memory cycles, then ready
        adv(); clr(); dmem_req = 1'b1; branch_taken = 1'b1;
        ID_EX_is_load = 1'b1; ID_EX_rt = 5'd9; IF_ID_rs = 5'd9;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) adv();
            settle(); lit("mem_freeze", V_FREEZE);
        end
        adv(); clr(); dmem_req = 1'b1; dmem_ready = 1'b1;
        settle(); lit("mem_ready_release", V_NORMAL);
        adv(); clr(); branch_taken = 1'b1;
        settle(); lit("run_after_mem", V_BRANCH);

        // Simultaneous start and done leaves the MDU busy
        adv(); clr(); mdu_start = 1'b1; mdu_done = 1'b1;
        settle(); lit("mdu_start_done_no_hilo", V_NORMAL);
        adv(); clr(); IF_ID_reads_hilo = 1'b1;
        settle(); lit("mdu_busy_hilo_stall", V_STALL);
        adv(); mdu_done = 1'b1;
        settle(); lit("mdu_done_releases", V_NORMAL);
        adv(); clr(); IF_ID_reads_hilo = 1'b1;
        settle(); lit("mdu_idle_hilo", V_NORMAL);

        // HI/LO stall across a six-cycle MDU operation, counted from a fresh reset
        adv(); clr(); rst = 1'b1;
        settle(); lit("mid_run_reset", V_RESET);
        adv(); rst = 1'b0; IF_ID_reads_hilo = 1'b1; mdu_start = 1'b1;
        settle(); lit("hilo_start_stall", V_STALL);
        for (int i = 1; i < 6; i++) begin
            adv(); mdu_start = 1'b0;
            settle(); chk("hilo_pc_en_held", 32'(pc_en), 32'd0);
        end
        adv(); mdu_done = 1'b1;
        settle(); lit("hilo_done_release", V_NORMAL);
        chk("hilo_stall_cycles", stall_cycles, exp_st);
        adv(); clr();
        settle(); lit("hilo_after", V_NORMAL);

        // Reset during MEM_WAIT returns to RUN
        adv(); clr(); dmem_req = 1'b1;
        settle(); lit("pre_reset_freeze", V_FREEZE);
        adv();
        settle(); lit("pre_reset_wait", V_FREEZE);
        adv(); rst = 1'b1;
        settle(); lit("reset_in_wait", V_RESET);
        adv(); rst = 1'b0; clr(); branch_taken = 1'b1;
        settle(); lit("run_after_wait_reset", V_BRANCH);

        // Timeout after MT waiting cycles, sticky until reset
        adv(); clr(); dmem_req = 1'b1;
        settle(); lit("to_freeze_0", V_FREEZE);
        for (int i = 1; i <= 4; i++) begin
            adv();
            settle();
            lit("to_freeze_n", V_FREEZE);
            chk("to_not_yet", 32'(mem_timeout), 32'd0);
        end
        adv();
        settle(); lit("timeout_halt", V_HALT);
        chk("timeout_flag", 32'(mem_timeout), 32'd1);
        adv(); dmem_ready = 1'b1; branch_taken = 1'b1;
        ID_EX_is_load = 1'b1; ID_EX_rt = 5'd4; IF_ID_rs = 5'd4;
        mdu_start = 1'b1; IF_ID_reads_hilo = 1'b1;
        settle(); lit("timeout_sticky_ctrl", V_HALT);
        chk("timeout_sticky_flag", 32'(mem_timeout), 32'd1);
        adv(); clr();
        settle(); chk("timeout_sticky_idle", 32'(mem_timeout), 32'd1);
        adv(); rst = 1'b1;
        settle(); lit("timeout_reset_ctrl", V_RESET);
        chk("timeout_reset_flag", 32'(mem_timeout), 32'd0);
        adv(); rst = 1'b0; clr(); branch_taken = 1'b1;
        settle(); lit("run_after_timeout", V_BRANCH);
        chk("run_after_timeout_flag", 32'(mem_timeout), 32'd0);

        adv(); clr();
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
